// File: rtl/overture_pkg.sv
// Shared encodings for the overture instruction sequencer: instruction classes,
// sequencer states, condition codes, write-data selects and special register indices.
package overture_pkg;

  typedef enum logic [1:0] {
    CLS_IMM  = 2'b00,
    CLS_CALC = 2'b01,
    CLS_COPY = 2'b10,
    CLS_COND = 2'b11
  } cls_e;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_EXEC     = 2'd1,
    ST_IN_WAIT  = 2'd2,
    ST_OUT_WAIT = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CC_NEVER  = 3'd0,
    CC_EQ     = 3'd1,
    CC_LT     = 3'd2,
    CC_LE     = 3'd3,
    CC_ALWAYS = 3'd4,
    CC_NE     = 3'd5,
    CC_GE     = 3'd6,
    CC_GT     = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    WSEL_IMM = 2'd0,
    WSEL_ALU = 2'd1,
    WSEL_REG = 2'd2,
    WSEL_IN  = 2'd3
  } wsel_e;

  // Register index 6 is the external I/O port in COPY; 7 is an ordinary register.
  localparam logic [2:0] IO_IDX      = 3'd6;
  localparam logic [2:0] IMM_DST_IDX = 3'd0;
  localparam logic [2:0] ALU_DST_IDX = 3'd3;

endpackage

// File: rtl/overture_cond_eval.sv
// Evaluates a CONDITION instruction's code against signed REG3.
module overture_cond_eval
  import overture_pkg::*;
(
  input  logic [7:0] reg3,
  input  logic [2:0] code,
  output logic       take
);

  logic is_zero;
  logic is_neg;

  assign is_zero = (reg3 == 8'd0);
  assign is_neg  = reg3[7];

  always_comb begin
    case (cond_e'(code))
      CC_NEVER:  take = 1'b0;
      CC_EQ:     take = is_zero;
      CC_LT:     take = is_neg;
      CC_LE:     take = is_neg | is_zero;
      CC_ALWAYS: take = 1'b1;
      CC_NE:     take = ~is_zero;
      CC_GE:     take = ~is_neg;
      CC_GT:     take = ~is_neg & ~is_zero;
      default:   take = 1'b0;
    endcase
  end

endmodule

// File: rtl/overture_sequencer.sv
// Fetch/execute sequencer for the overture 8-bit instruction set; drives an
// external register file and byte-wide input/output handshakes.
module overture_sequencer
  import overture_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] prog_addr,
  output logic            prog_req,
  input  logic            prog_ack,
  input  logic [7:0]      prog_data,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [7:0]      out_data,
  input  logic            out_ready,
  output logic            rf_we,
  output logic [2:0]      rf_dst,
  output logic [2:0]      rf_src,
  output logic [1:0]      wsel,
  output logic [5:0]      imm,
  output logic [2:0]      alu_op,
  output logic [7:0]      io_data,
  input  logic [7:0]      reg_rdata,
  input  logic [PC_W-1:0] reg0,
  input  logic [7:0]      reg3,
  output logic            halted_idle
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      io_q, io_d;
  logic [7:0]      out_q, out_d;
  logic            in_got_q, in_got_d;
  logic            take;
  wsel_e           wsel_w;
  logic [2:0]      cp_src, cp_dst;

  assign cp_src = ir_q[5:3];
  assign cp_dst = ir_q[2:0];
  assign pc_inc = pc_q + 1'b1;

  overture_cond_eval u_cond (
    .reg3 (reg3),
    .code (ir_q[2:0]),
    .take (take)
  );

  // NOTE: every output and next-state value gets a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    io_d      = io_q;
    out_d     = out_q;
    in_got_d  = in_got_q;
    prog_req  = 1'b0;
    rf_we     = 1'b0;
    rf_dst    = 3'd0;
    wsel_w    = WSEL_IMM;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_FETCH: begin
        prog_req = run & ~rst;
        if (run && prog_ack) begin
          ir_d    = prog_data;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (cls_e'(ir_q[7:6]))
          CLS_IMM: begin
            rf_we   = 1'b1;
            rf_dst  = IMM_DST_IDX;
            wsel_w  = WSEL_IMM;
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
          CLS_CALC: begin
            rf_we   = 1'b1;
            rf_dst  = ALU_DST_IDX;
            wsel_w  = WSEL_ALU;
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
          CLS_COPY: begin
            // An input copy revisits EXEC once the byte is latched to write it.
            if (cp_src == IO_IDX) begin
              if (in_got_q) begin
                rf_we    = 1'b1;
                rf_dst   = cp_dst;
                wsel_w   = WSEL_IN;
                pc_d     = pc_inc;
                in_got_d = 1'b0;
                state_d  = ST_FETCH;
              end else begin
                state_d = ST_IN_WAIT;
              end
            end else if (cp_dst == IO_IDX) begin
              out_d   = reg_rdata;
              state_d = ST_OUT_WAIT;
            end else begin
              rf_we   = 1'b1;
              rf_dst  = cp_dst;
              wsel_w  = WSEL_REG;
              pc_d    = pc_inc;
              state_d = ST_FETCH;
            end
          end
          default: begin
            pc_d    = take ? reg0 : pc_inc;
            state_d = ST_FETCH;
          end
        endcase
      end

      ST_IN_WAIT: begin
        in_ready = in_valid;
        if (in_valid) begin
          io_d = in_data;
          if (cp_dst == IO_IDX) begin
            out_d   = in_data;
            state_d = ST_OUT_WAIT;
          end else begin
            in_got_d = 1'b1;
            state_d  = ST_EXEC;
          end
        end
      end

      ST_OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above; reset clears all of them, so an
  // interrupted instruction leaves no pending write or input flag behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= 8'd0;
      io_q     <= 8'd0;
      out_q    <= 8'd0;
      in_got_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      io_q     <= io_d;
      out_q    <= out_d;
      in_got_q <= in_got_d;
    end
  end

  assign prog_addr   = pc_q;
  assign rf_src      = cp_src;
  assign wsel        = wsel_w;
  assign imm         = ir_q[5:0];
  assign alu_op      = ir_q[2:0];
  assign io_data     = io_q;
  assign out_data    = out_q;
  assign halted_idle = (state_q == ST_FETCH) && !run;

endmodule

// File: doc/overture_sequencer.md
OVERTURE_SEQUENCER -- requirements
Module: overture_sequencer

Interface
REQ-001 The block SHALL have one parameter: PC_W, default 8, program-counter and jump-target width.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  1 = sequencing enabled; 0 = stall in FETCH
- prog_addr  out  PC_W  instruction address (= PC)
- prog_req  out  1  fetch request
- prog_ack  in  1  prog_data valid this cycle
- prog_data  in  8  instruction byte
- in_valid  in  1  external input byte offered
- in_data  in  8  external input byte
- in_ready  out  1  input byte consumed this cycle
- out_valid  out  1  output byte offered
- out_data  out  8  output byte
- out_ready  in  1  output consumer accepts
- rf_we  out  1  register-file write strobe
- rf_dst  out  3  write register index
- rf_src  out  3  read register index for copy
- wsel  out  2  write-data select: 0 imm, 1 ALU, 2 register, 3 input latch
- imm  out  6  immediate field IR[5:0]
- alu_op  out  3  IR[2:0] during calculation
- io_data  out  8  latched input byte (wsel=3 source)
- reg_rdata  in  8  register-file read data at rf_src
- reg0  in  PC_W  REG0 contents (jump target)
- reg3  in  8  REG3 contents (condition operand, signed)
- halted_idle  out  1  1 when in FETCH with run=0

Function
REQ-003 Class SHALL be IR[7:6]: 00 IMMEDIATE, 01 CALCULATION, 10 COPY, 11 CONDITION.
REQ-004 States SHALL be FETCH, EXEC, IN_WAIT, OUT_WAIT.
REQ-005 FETCH: prog_req = run; on prog_req & prog_ack, IR <= prog_data, next EXEC; otherwise remain.
REQ-006 EXEC IMMEDIATE: rf_we=1, rf_dst=0, wsel=0 for one cycle; PC <= PC+1; next FETCH.
REQ-007 EXEC CALCULATION: rf_we=1, rf_dst=3, wsel=1, alu_op=IR[2:0] for one cycle; PC <= PC+1; next FETCH.
REQ-008 EXEC COPY: src=IR[5:3], dst=IR[2:0]; index 6 as src SHALL mean external input and as dst external output; index 7 SHALL be a normal register.
REQ-009 COPY with src!=6, dst!=6: rf_we=1, rf_src=src, rf_dst=dst, wsel=2 in EXEC; PC+1; next FETCH.
REQ-010 COPY with src=6: next IN_WAIT; in IN_WAIT, in_ready = in_valid; on in_valid, io_data <= in_data; if dst!=6, next cycle write with rf_dst=dst, wsel=3, PC+1, then FETCH; if dst=6, next OUT_WAIT with out_data=io_data.
REQ-011 COPY with dst=6, src!=6: out_data <= reg_rdata (rf_src=src) at end of EXEC; next OUT_WAIT.
REQ-012 OUT_WAIT: out_valid=1 and out_data stable until out_ready; on out_valid & out_ready, PC <= PC+1, next FETCH.
REQ-013 EXEC CONDITION: evaluate signed reg3 by IR[2:0]: 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0; true -> PC <= reg0, else PC+1; next FETCH; rf_we=0.
REQ-014 PC SHALL wrap modulo 2^PC_W (max+1 -> 0).
REQ-015 rf_we, in_ready, out_valid SHALL never be asserted outside the states above; at most one rf_we per instruction.
REQ-016 run=0 SHALL only gate a new fetch; instructions in EXEC/IN_WAIT/OUT_WAIT complete.
REQ-017 prog_ack while prog_req=0 SHALL be ignored.
REQ-018 Minimum latency SHALL be 2 cycles per non-IO instruction with zero-wait prog_ack.

Reset
REQ-019 While rst=1: state FETCH, PC=0, IR=0, io_data=0, out_data=0; prog_req, rf_we, in_ready and out_valid forced 0.
REQ-020 Reset mid-instruction SHALL abandon it without write, output or input consumption; first fetch after release SHALL be address 0.

Structure
REQ-021 Class encodings, state encoding, condition codes, I/O index 6 and wsel codes SHALL live in shared package overture_pkg.
REQ-022 Condition evaluation SHALL be sub-module overture_cond_eval (reg3, code -> take); everything else in one module.

Verification
REQ-023 Program 00_000101 at addr 0, ack same cycle -> rf_we pulse with rf_dst=0, wsel=0, imm=5; next prog_addr=1, 2 cycles total.
REQ-024 COPY 10_110_011 with in_valid delayed 3 cycles, in_data=0xA5 -> in_ready single pulse, then rf_we with rf_dst=3, wsel=3, io_data=0xA5.
REQ-025 COPY 10_001_110, reg_rdata=0x3C, out_ready low 4 cycles -> out_valid held with out_data=0x3C; PC advances only on handshake.
REQ-026 CONDITION 11_000_010 with reg3=0x80, reg0=0x20 -> PC=0x20; reg3=0x00 -> PC+1.
REQ-027 PC=0xFF, IMMEDIATE executed -> next prog_addr=0x00.
REQ-028 rst asserted in OUT_WAIT -> out_valid=0 immediately, PC=0, no further rf_we; after release, fetch at 0.
